uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver for 8N1 frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high); idle line is high.
- Recovers bytes from the external RX pin and presents them to the CPU-side bus logic with a valid/ack handshake.
- Flags overrun and framing errors.
- Bit timing matches the team's transmitter: one bit period is CLKS_PER_BIT+1 clock cycles.

Parameters:
- CLKS_PER_BIT, 120: bit period minus one, in I_clk cycles. Legal range is 4..65534.
- HALF_BIT, CLKS_PER_BIT/2 (integer division, derived, not overridable): counter value at which the start bit is sampled.

Ports:
- I_clk  input  1  system clock; all logic on its rising edge
- I_reset  input  1  synchronous, active-high reset
- I_rx  input  1  raw serial line; asynchronous to I_clk
- I_ack  input  1  consumer acknowledges the byte currently held on O_data
- O_data  output  8  last received byte; stable while O_valid=1
- O_valid  output  1  byte available; held until I_ack
- O_overrun  output  1  sticky: a byte was completed while O_valid=1 and no I_ack was given; cleared by I_ack
- O_frame_err  output  1  one-cycle pulse: stop bit sampled low
- O_busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values (applied when I_reset=1 on a clock edge, including mid-frame):
  - O_data=0, O_valid=0, O_overrun=0, O_frame_err=0, O_busy=0
  - FSM=IDLE, clk_count=0, bit_idx=0
  - Synchronizer flops preset to 1
  - Any partial frame is discarded.
- Synchronizer: I_rx passes through 2 flops giving rx_s. All FSM decisions use rx_s only. This adds 2 cycles of latency and is not compensated.
- Counter: clk_count is 16 bits, unsigned, and is cleared on every state or bit transition.
- IDLE:
  - rx_s=0 -> START, clk_count=0.
- START:
  - clk_count increments each cycle.
  - At clk_count==HALF_BIT, sample rx_s:
    - rx_s=0 -> DATA, bit_idx=0, clk_count=0.
    - rx_s=1 -> glitch; return to IDLE with no output and no flag.
- DATA:
  - clk_count increments each cycle.
  - At clk_count==CLKS_PER_BIT: shift[bit_idx] <= rx_s, clk_count=0.
  - If bit_idx==7 -> STOP, else bit_idx+1.
  - Samples therefore land at mid-bit.
- STOP:
  - At clk_count==CLKS_PER_BIT, sample rx_s:
    - rx_s=1 -> deliver and go to IDLE. No wait for the end of the stop bit, so back-to-back frames are accepted.
    - rx_s=0 -> O_frame_err pulses for 1 cycle, byte is discarded (O_data, O_valid, O_overrun unchanged) -> WAIT_HIGH.
- WAIT_HIGH:
  - Remain until rx_s=1, then IDLE. This prevents a break condition from being decoded as repeated frames.
- Deliver (the cycle after the stop sample edge):
  - O_data <= shift register, O_valid <= 1.
  - If O_valid was already 1 and I_ack=0 in the stop-sample cycle, O_overrun <= 1. The new byte overwrites O_data.
- Handshake:
  - I_ack=1 while O_valid=1 -> O_valid <= 0 and O_overrun <= 0 next cycle.
  - I_ack while O_valid=0 is ignored.
- Simultaneous I_ack and delivery in the same cycle: the new byte loads, O_valid stays 1, and O_overrun is 0. Delivery takes priority over the ack clear.
- Reset asserted during any state takes precedence over every other event.
- O_busy is registered; it equals (next state != IDLE).

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3, WAIT_HIGH=4 (3 bits).
  - UART_DATA_BITS=8.
  - Default CLKS_PER_BIT=120, for reuse by the transmitter.
- One sub-module, uart_rx_sync: a 2-flop synchronizer with parameterized reset value (1 here), clocked by I_clk and reset by I_reset.
- FSM, counter and shift register stay in uart_rx.

Test Plan:
- CLKS_PER_BIT=8 (9-cycle bits), send 0xA5 as an ideal frame -> O_valid rises 1 cycle after the stop-bit mid-sample with O_data=0xA5, O_frame_err never pulses; I_ack one cycle later -> O_valid=0.
- Two back-to-back frames 0x3C then 0xC3, I_ack given after each -> two deliveries in order, O_overrun stays 0; a second frame starting immediately after the stop bit is accepted.
- Send 0x11 then 0x22 without ever asserting I_ack -> O_data=0x22, O_valid=1, O_overrun=1; a single I_ack clears both.
- 3-cycle low glitch on an idle line -> START aborts at the HALF_BIT sample, returns to IDLE, no O_valid and no flags.
- Frame 0x55 with the stop bit forced low and the line held low for 30 cycles -> one O_frame_err pulse, O_valid unchanged, FSM stays in WAIT_HIGH until the line rises, then a following frame 0x0F is received correctly.
- Assert I_reset for 1 cycle mid-DATA of a frame 0xFF -> next cycle all outputs are 0 and O_busy=0, the partial byte is never delivered, and the next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver (and its matching transmitter):
// frame width, default bit timing, FSM state encodings and a helper that
// derives the mid-start-bit sample point from the bit timing.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS             = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT  = 120;
    localparam int UART_COUNT_WIDTH           = 16;

    typedef logic [UART_DATA_BITS-1:0]   uart_byte_t;
    typedef logic [UART_COUNT_WIDTH-1:0] uart_count_t;
    typedef logic [2:0]                  uart_state_t;

    // Receiver FSM encodings; kept as plain constants so the transmitter
    // and older tools can share them.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Counter value at which the start bit is re-checked (half a bit period).
    function automatic uart_count_t uart_half_bit(input int clks_per_bit);
        return uart_count_t'(clks_per_bit / 2);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// ---------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer bringing an asynchronous input into the I_clk domain.
// Both flops load RESET_VALUE on reset so an idle-high line does not look
// like a start bit while the chain refills.
//
// Ports:
//   I_clk    system clock
//   I_reset  synchronous, active-high reset
//   I_d      asynchronous input
//   O_q      synchronized output (2 cycles of latency)
// ---------------------------------------------------------------------------
module uart_rx_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic I_clk,
    input  logic I_reset,
    input  logic I_d,
    output logic O_q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= I_d;
            sync_q <= meta_q;
        end
    end

    assign O_q = sync_q;

endmodule : uart_rx_sync

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver. Recovers bytes from the RX pin and hands them to the
// CPU side with a valid/ack handshake; flags overrun and framing errors.
// One bit period is CLKS_PER_BIT+1 cycles, matching the transmitter.
//
// Ports:
//   I_clk        system clock
//   I_reset      synchronous, active-high reset
//   I_rx         raw serial line (asynchronous)
//   I_ack        consumer takes the byte on O_data
//   O_data       last received byte, stable while O_valid=1
//   O_valid      byte available, held until I_ack
//   O_overrun    sticky: a byte arrived while the previous one was unacked
//   O_frame_err  one-cycle pulse: stop bit sampled low
//   O_busy       FSM is not in IDLE
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge on rx_s
// START     | counting to half a bit, then confirming the start bit is low
// DATA      | sampling 8 data bits, one per bit period, LSB first
// STOP      | sampling the stop bit; deliver on high, framing error on low
// WAIT_HIGH | after a framing error, wait for the line to return high
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      I_clk,
    input  logic                      I_reset,
    input  logic                      I_rx,
    input  logic                      I_ack,
    output logic [UART_DATA_BITS-1:0] O_data,
    output logic                      O_valid,
    output logic                      O_overrun,
    output logic                      O_frame_err,
    output logic                      O_busy
);

    localparam uart_count_t CPB      = uart_count_t'(CLKS_PER_BIT);
    localparam uart_count_t HALF_BIT = uart_half_bit(CLKS_PER_BIT);
    localparam logic [2:0]  LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_state_t state_q,     state_d;
    uart_count_t clk_count_q, clk_count_d;
    logic [2:0]  bit_idx_q,   bit_idx_d;
    uart_byte_t  shift_q,     shift_d;
    uart_byte_t  data_q,      data_d;
    logic        valid_q,     valid_d;
    logic        overrun_q,   overrun_d;
    logic        frame_err_q, frame_err_d;
    logic        busy_q,      busy_d;

    uart_rx_sync #(
        .RESET_VALUE (1'b1)
    ) u_sync (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .I_d     (I_rx),
        .O_q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;

        // Ack is applied first so that a delivery in the same cycle wins.
        if (I_ack && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                clk_count_d = '0;
                bit_idx_d   = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (clk_count_q == HALF_BIT) begin
                    clk_count_d = '0;
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_idx_d = '0;
                    end else begin
                        // Too short to be a start bit: drop it silently.
                        state_d = ST_IDLE;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (clk_count_q == CPB) begin
                    clk_count_d        = '0;
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end

            ST_STOP: begin
                if (clk_count_q == CPB) begin
                    clk_count_d = '0;
                    if (rx_s) begin
                        // Return to IDLE at mid-stop-bit so a frame that
                        // starts right after this stop bit is not missed.
                        state_d   = ST_IDLE;
                        data_d    = shift_q;
                        valid_d   = 1'b1;
                        overrun_d = overrun_q | (valid_q & ~I_ack);
                        if (I_ack) begin
                            overrun_d = 1'b0;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    clk_count_d = clk_count_q + 1'b1;
                end
            end

            ST_WAIT_HIGH: begin
                clk_count_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                clk_count_d = '0;
                bit_idx_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q     <= ST_IDLE;
            clk_count_q <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_count_q <= clk_count_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign O_data      = data_q;
    assign O_valid     = valid_q;
    assign O_overrun   = overrun_q;
    assign O_frame_err = frame_err_q;
    assign O_busy      = busy_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with CLKS_PER_BIT=8 (9-cycle bits).
// Frames are driven as ideal 8N1 waveforms; a consumer process records each
// delivered byte and optionally acknowledges it. Expected bytes and error
// counts come from the frame contents alone (stop high -> byte delivered,
// stop low -> one framing-error pulse, nothing delivered).
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB  = 8;
    localparam int BITC = CPB + 1;
    localparam int HALF = CPB / 2;
    // Start edge -> O_valid visible: 2 synchronizer edges, 1 edge for IDLE to
    // react, HALF+1 edges in START, then 8 data + 1 stop bit periods.
    localparam int LAT  = 2 + 1 + (HALF + 1) + 9 * BITC;
    localparam int NVEC = 22;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       ack_man  = 1'b0;
    logic       ack_auto = 1'b0;
    logic       auto_en  = 1'b0;
    logic       ack;
    logic [7:0] data;
    logic       valid, ovr, ferr, busy;

    assign ack = ack_man | ack_auto;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .I_clk       (clk),
        .I_reset     (rst),
        .I_rx        (rx),
        .I_ack       (ack),
        .O_data      (data),
        .O_valid     (valid),
        .O_overrun   (ovr),
        .O_frame_err (ferr),
        .O_busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer / monitor: samples on the falling edge.
    logic [7:0] got_q[$];
    int         got_cyc[$];
    int         ferr_pulses = 0;
    int         ferr_hi     = 0;
    logic       ferr_prev   = 1'b0;

    always @(negedge clk) begin
        if (ferr) ferr_hi <= ferr_hi + 1;
        if (ferr && !ferr_prev) ferr_pulses <= ferr_pulses + 1;
        ferr_prev <= ferr;
        if (auto_en && valid && !ack_auto) begin
            got_q.push_back(data);
            got_cyc.push_back(cyc);
            ack_auto <= 1'b1;
        end else begin
            ack_auto <= 1'b0;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on a falling edge with the line high.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        rx = stop;
        repeat (BITC) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic pulse_ack();
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_deliver;
        int         exp_err;
    } vec_t;

    vec_t vecs[NVEC];

    initial begin
        int c0, n0, p0, h0, k;
        logic seen_busy;

        // Table: directed entries first, random ones after. Expected
        // outcome follows from the stop bit alone.
        vecs[0] = '{8'h00, 1'b1, 0, 0, 0};
        vecs[1] = '{8'hFF, 1'b1, 2, 0, 0};
        vecs[2] = '{8'h80, 1'b1, 0, 0, 0};
        vecs[3] = '{8'h01, 1'b0, 5, 0, 0};
        vecs[4] = '{8'h6B, 1'b1, 1, 0, 0};
        vecs[5] = '{8'h00, 1'b0, 3, 0, 0};
        for (int i = 6; i < NVEC; i++) begin
            vecs[i].data = 8'($urandom);
            vecs[i].stop = ($urandom_range(0, 4) != 0);
            vecs[i].gap  = int'($urandom_range(0, 15));
        end
        for (int i = 0; i < NVEC; i++) begin
            if (!vecs[i].stop && vecs[i].gap < 3) vecs[i].gap = 3;
            vecs[i].exp_deliver = vecs[i].stop ? 1 : 0;
            vecs[i].exp_err     = vecs[i].stop ? 0 : 1;
        end

        // Reset state
        idle(2);
        check("reset_data",  32'(data),  32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_ovr",   32'(ovr),   32'h0);
        check("reset_ferr",  32'(ferr),  32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        rst = 1'b0;
        idle(3);

        // Ideal frame 0xA5, exact delivery latency, auto ack
        auto_en = 1'b1;
        idle(1);
        p0 = ferr_pulses;
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        idle(3);
        check("a5_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) begin
            check("a5_data",    32'(got_q[0]), 32'hA5);
            check("a5_latency", 32'(got_cyc[0] - c0), 32'(LAT));
        end
        check("a5_valid_after_ack", 32'(valid), 32'h0);
        check("a5_no_ferr", 32'(ferr_pulses - p0), 32'd0);
        got_q.delete(); got_cyc.delete();

        // Back-to-back 0x3C, 0xC3
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(3);
        check("b2b_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("b2b_first",  32'(got_q[0]), 32'h3C);
            check("b2b_second", 32'(got_q[1]), 32'hC3);
        end
        check("b2b_ovr", 32'(ovr), 32'h0);
        got_q.delete(); got_cyc.delete();

        // Overrun: 0x11 then 0x22 with no ack
        auto_en = 1'b0;
        idle(2);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(2);
        check("ovr_data",  32'(data),  32'h22);
        check("ovr_valid", 32'(valid), 32'h1);
        check("ovr_flag",  32'(ovr),   32'h1);
        pulse_ack();
        check("ovr_ack_valid", 32'(valid), 32'h0);
        check("ovr_ack_flag",  32'(ovr),   32'h0);

        // Ack in the same cycle as a delivery: new byte held, no overrun
        send_frame(8'h44, 1'b1);
        idle(1);
        c0 = cyc;
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                ack_man = 1'b1;
                @(negedge clk);
                ack_man = 1'b0;
            end
        join
        check("coinc_data",  32'(data),  32'h99);
        check("coinc_valid", 32'(valid), 32'h1);
        check("coinc_ovr",   32'(ovr),   32'h0);
        pulse_ack();
        check("coinc_cleared", 32'(valid), 32'h0);

        // 3-cycle glitch on idle line
        auto_en = 1'b1;
        idle(2);
        n0 = got_q.size();
        p0 = ferr_pulses;
        seen_busy = 1'b0;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy) seen_busy = 1'b1;
        end
        check("glitch_busy_seen", 32'(seen_busy), 32'h1);
        check("glitch_busy_end",  32'(busy),      32'h0);
        check("glitch_no_byte",   32'(got_q.size() - n0), 32'd0);
        check("glitch_no_ferr",   32'(ferr_pulses - p0),  32'd0);

        // Framing error on 0x55 with a held-low line; pending byte untouched
        auto_en = 1'b0;
        idle(2);
        send_frame(8'h5A, 1'b1);
        p0 = ferr_pulses;
        h0 = ferr_hi;
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        idle(30);
        check("ferr_pulse",      32'(ferr_pulses - p0), 32'd1);
        check("ferr_width",      32'(ferr_hi - h0),     32'd1);
        check("ferr_data_kept",  32'(data),  32'h5A);
        check("ferr_valid_kept", 32'(valid), 32'h1);
        check("ferr_ovr",        32'(ovr),   32'h0);
        check("ferr_wait_high",  32'(busy),  32'h1);
        rx = 1'b1;
        idle(5);
        check("ferr_released", 32'(busy), 32'h0);
        pulse_ack();
        auto_en = 1'b1;
        got_q.delete(); got_cyc.delete();
        send_frame(8'h0F, 1'b1);
        idle(3);
        check("after_ferr_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("after_ferr_data", 32'(got_q[0]), 32'h0F);
        got_q.delete(); got_cyc.delete();

        // Reset mid-DATA of 0xFF with a pending byte
        auto_en = 1'b0;
        idle(2);
        send_frame(8'h77, 1'b1);
        fork
            send_frame(8'hFF, 1'b1);
            begin
                idle(40);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_data",  32'(data),  32'h0);
                check("rst_valid", 32'(valid), 32'h0);
                check("rst_ovr",   32'(ovr),   32'h0);
                check("rst_ferr",  32'(ferr),  32'h0);
                check("rst_busy",  32'(busy),  32'h0);
            end
        join
        idle(5);
        check("rst_no_partial", 32'(valid), 32'h0);
        auto_en = 1'b1;
        send_frame(8'h81, 1'b1);
        idle(3);
        check("after_rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check("after_rst_data", 32'(got_q[0]), 32'h81);
        got_q.delete(); got_cyc.delete();

        // Table-driven directed + random frames
        idle(2);
        for (int i = 0; i < NVEC; i++) begin
            n0 = got_q.size();
            p0 = ferr_pulses;
            send_frame(vecs[i].data, vecs[i].stop);
            idle(vecs[i].gap);
            k = 0;
            while (got_q.size() - n0 < vecs[i].exp_deliver && k < 4 * BITC) begin
                @(negedge clk);
                k++;
            end
            check($sformatf("vec%0d_deliver", i), 32'(got_q.size() - n0), 32'(vecs[i].exp_deliver));
            if (vecs[i].exp_deliver == 1 && got_q.size() > n0)
                check($sformatf("vec%0d_data", i), 32'(got_q[n0]), 32'(vecs[i].data));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_pulses - p0), 32'(vecs[i].exp_err));
        end
        idle(4);
        check("final_ovr",  32'(ovr),  32'h0);
        check("final_busy", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_uart_rx
